// File: rtl/fifo_fwft_counted.sv
// First-word-fall-through FIFO for any DEPTH >= 2, with occupancy count, almost flags and write-through when full.
// Optional sticky OVERFLOW/UNDERFLOW flags are built only when FIFO_ERR_FLAGS_EN is defined.
module fifo_fwft_counted #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = 28,
  parameter int AE_THRESH = 4,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] DIN,
  input  logic             WE,
  input  logic             RE,
  output logic [WIDTH-1:0] DOUT,
  output logic             NOT_EMPTY,
  output logic             FULL,
  output logic             ALMOST_FULL,
  output logic             ALMOST_EMPTY,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  if (WIDTH < 1 || DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
      AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_param_check
    $fatal(1, "fifo_fwft_counted: illegal WIDTH/DEPTH/AF_THRESH/AE_THRESH");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wp_reg, rp_reg;
  logic [PTR_W-1:0] wp_next, rp_next;
  logic [PTR_W-1:0] wp_inc, rp_inc;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] dout_reg;
  logic             not_empty_reg, full_reg, af_reg, ae_reg;
  logic             rd_acc, wr_acc;

  // A full FIFO still takes a write when the head is popped in the same cycle.
  always_comb begin
    rd_acc = RE & not_empty_reg;
    wr_acc = WE & (~full_reg | rd_acc);
  end

  // Explicit wrap so non-power-of-two depths work.
  always_comb begin
    wp_inc  = (wp_reg == PTR_MAX) ? '0 : wp_reg + PTR_W'(1);
    rp_inc  = (rp_reg == PTR_MAX) ? '0 : rp_reg + PTR_W'(1);
    wp_next = wr_acc ? wp_inc : wp_reg;
    rp_next = rd_acc ? rp_inc : rp_reg;
  end

  always_comb begin
    count_next = count_reg;
    if (wr_acc && !rd_acc) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!wr_acc && rd_acc) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      mem[wp_reg] <= DIN;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      wp_reg        <= '0;
      rp_reg        <= '0;
      count_reg     <= '0;
      dout_reg      <= '0;
      not_empty_reg <= 1'b0;
      full_reg      <= 1'b0;
      af_reg        <= 1'b0;
      ae_reg        <= 1'b1;
    end else begin
      wp_reg        <= wp_next;
      rp_reg        <= rp_next;
      count_reg     <= count_next;
      not_empty_reg <= (count_next != '0);
      full_reg      <= (count_next == DEPTH_C);
      af_reg        <= (count_next >= AF_C);
      ae_reg        <= (count_next <= AE_C);
      // New head is the word being written when it lands where the read pointer is heading.
      if (wr_acc && (wp_reg == rp_next)) begin
        dout_reg <= DIN;
      end else if (rd_acc) begin
        dout_reg <= mem[rp_next];
      end
    end
  end

  assign DOUT         = dout_reg;
  assign NOT_EMPTY    = not_empty_reg;
  assign FULL         = full_reg;
  assign ALMOST_FULL  = af_reg;
  assign ALMOST_EMPTY = ae_reg;
  assign COUNT        = count_reg;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_reg, underflow_reg;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (WE && full_reg && !rd_acc) begin
        overflow_reg <= 1'b1;
      end
      if (RE && !not_empty_reg) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign OVERFLOW  = overflow_reg;
  assign UNDERFLOW = underflow_reg;
`else
  assign OVERFLOW  = 1'b0;
  assign UNDERFLOW = 1'b0;
`endif

endmodule
